fact_cu: RTL and testbench

Control unit (FSM) for the 32-bit iterative factorial datapath DP; drives the DP control inputs and consumes its GT status. Accepts a GO/N request, range-checks N, sequences the load/multiply/decrement loop, then presents DONE, which also enables the DP output buffer. DP and fact_cu together form the complete factorial engine; top-level integration is a separate block.

---
 rtl/fact_pkg.sv | 20 ++
 rtl/fact_cu.sv | 92 +++++++++
 tb/tb_fact_cu.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/fact_pkg.sv
// rtl/fact_pkg.sv - shared encodings and defaults for the factorial control unit and datapath
// Keep these in step with DP; it uses the same WIDTH/MAX_N defaults and mux select meaning.
package fact_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int MAX_N_DEF = 12;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CHK  = 3'd2,
    S_MUL  = 3'd3,
    S_FIN  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic MUX_ONE  = 1'b0;
  localparam logic MUX_PROD = 1'b1;

endpackage

// File: rtl/fact_cu.sv
// rtl/fact_cu.sv - Moore control FSM sequencing the iterative factorial datapath
// Outputs are decoded purely from the state register so reset clears them asynchronously.
module fact_cu
  import fact_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int MAX_N = MAX_N_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             GO,
  input  logic [WIDTH-1:0] N,
  input  logic             GT,
  output logic             CNT_LD,
  output logic             CNT_EN,
  output logic             MUX,
  output logic             REG_LD,
  output logic             DONE,
  output logic             ERR,
  output logic             BUSY
);

  localparam logic [WIDTH-1:0] MAX_N_W = WIDTH'(MAX_N);

  state_t state;
  state_t state_nxt;
  logic   n_ok;

  assign n_ok = (N <= MAX_N_W);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Unused encodings fall through to the default and recover to IDLE.
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE: begin
        if (GO) begin
          state_nxt = n_ok ? S_LOAD : S_ERR;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_LOAD: state_nxt = S_CHK;
      S_CHK:  state_nxt = GT ? S_MUL : S_FIN;
      S_MUL:  state_nxt = S_CHK;
      S_FIN:  state_nxt = GO ? S_FIN : S_IDLE;
      S_ERR:  state_nxt = GO ? S_ERR : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    CNT_LD = 1'b0;
    CNT_EN = 1'b0;
    MUX    = MUX_ONE;
    REG_LD = 1'b0;
    DONE   = 1'b0;
    ERR    = 1'b0;
    BUSY   = 1'b0;
    case (state)
      S_LOAD: begin
        CNT_LD = 1'b1;
        REG_LD = 1'b1;
        MUX    = MUX_ONE;
        BUSY   = 1'b1;
      end
      S_CHK: begin
        BUSY = 1'b1;
      end
      S_MUL: begin
        CNT_EN = 1'b1;
        REG_LD = 1'b1;
        MUX    = MUX_PROD;
        BUSY   = 1'b1;
      end
      S_FIN: DONE = 1'b1;
      S_ERR: ERR  = 1'b1;
      default: ;
    endcase
  end

  a_ld_en_excl: assert property (@(posedge CLK) disable iff (!RST_N) !(CNT_LD && CNT_EN));
  a_done_busy_excl: assert property (@(posedge CLK) disable iff (!RST_N) !(DONE && BUSY));

endmodule

// File: tb/tb_fact_cu.sv
// tb/tb_fact_cu.sv - directed bench for fact_cu driving a behavioural factorial datapath
// Expected cycle counts and results are hand-computed from the factorial latency rule.
module tb_fact_cu;
  import fact_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        GO = 1'b0;
  logic [31:0] N = '0;
  logic        GT;
  logic        CNT_LD, CNT_EN, MUX, REG_LD, DONE, ERR, BUSY;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] cnt = '0;
  logic [31:0] prod = '0;
  logic [31:0] dout;
  logic [6:0]  outs;

  fact_cu #(.WIDTH(32), .MAX_N(12)) dut (
    .CLK(CLK), .RST_N(RST_N), .GO(GO), .N(N), .GT(GT),
    .CNT_LD(CNT_LD), .CNT_EN(CNT_EN), .MUX(MUX), .REG_LD(REG_LD),
    .DONE(DONE), .ERR(ERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Datapath model: down-counter, product register and DONE-gated output buffer.
  always @(posedge CLK) begin
    if (CNT_LD) cnt <= N;
    else if (CNT_EN) cnt <= cnt - 32'd1;
    if (REG_LD) prod <= MUX ? prod * cnt : 32'd1;
  end
  assign GT   = (cnt > 32'd1);
  assign dout = DONE ? prod : 32'd0;
  assign outs = {CNT_LD, CNT_EN, MUX, REG_LD, DONE, ERR, BUSY};

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RST_N) check("ld_en_excl", int'(CNT_LD & CNT_EN), 0);
  end

  task automatic run(input logic [31:0] n, input bit keep_go,
                     output int done_cyc, output int err_cyc, output int busy_cyc,
                     output int en_cnt, output int mul_ld, output int res);
    done_cyc = -1; err_cyc = -1; busy_cyc = 0; en_cnt = 0; mul_ld = 0; res = 0;
    @(negedge CLK);
    N  = n;
    GO = 1'b1;
    @(posedge CLK);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge CLK);
      if (!keep_go) GO = 1'b0;
      if (BUSY) busy_cyc++;
      if (CNT_EN) en_cnt++;
      if (REG_LD && MUX) mul_ld++;
      if (DONE) begin done_cyc = cyc; res = int'(dout); break; end
      if (ERR) begin err_cyc = cyc; break; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int dc, ec, bc, en, ml, rs;

  initial begin
    repeat (2) @(posedge CLK);
    #1 check("reset_outs", int'(outs), 0);
    @(negedge CLK) RST_N = 1'b1;

    // N=5 with GO held through DONE
    run(32'd5, 1'b1, dc, ec, bc, en, ml, rs);
    check("n5_done_cyc", dc, 11);
    check("n5_result", rs, 120);
    check("n5_busy", bc, 10);
    check("n5_cnt_en", en, 4);
    check("n5_mul_ld", ml, 4);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK) check("n5_done_hold", int'(outs), 7'b0000100);
    end
    GO = 1'b0;
    @(negedge CLK) check("n5_back_idle", int'(outs), 0);

    // N=0 and N=1, GO pulsed
    for (int k = 0; k < 2; k++) begin
      run(32'(k), 1'b0, dc, ec, bc, en, ml, rs);
      check("n01_done_cyc", dc, 3);
      check("n01_result", rs, 1);
      check("n01_cnt_en", en, 0);
      check("n01_mul_ld", ml, 0);
      @(negedge CLK) check("n01_done_one_cycle", int'(DONE), 0);
    end

    // N=12 (largest accepted)
    run(32'd12, 1'b0, dc, ec, bc, en, ml, rs);
    check("n12_done_cyc", dc, 25);
    check("n12_result", rs, 479001600);
    check("n12_cnt_en", en, 11);
    @(negedge CLK);

    // N=13 rejected, GO held then dropped
    run(32'd13, 1'b1, dc, ec, bc, en, ml, rs);
    check("n13_err_cyc", ec, 1);
    check("n13_no_done", dc, -1);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK) check("n13_err_hold", int'(outs), 7'b0000010);
    end
    GO = 1'b0;
    @(negedge CLK) check("n13_back_idle", int'(outs), 0);

    // Unsigned compare: all-ones is out of range
    run(32'hFFFF_FFFF, 1'b0, dc, ec, bc, en, ml, rs);
    check("nmax_err_cyc", ec, 1);
    check("nmax_busy", bc, 0);
    @(negedge CLK);

    // One result per request while GO stays high, then re-request
    run(32'd2, 1'b1, dc, ec, bc, en, ml, rs);
    check("n2_done_cyc", dc, 5);
    check("n2_result", rs, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK) check("n2_single_run", int'(outs), 7'b0000100);
    end
    GO = 1'b0;
    run(32'd3, 1'b0, dc, ec, bc, en, ml, rs);
    check("n3_done_cyc", dc, 7);
    check("n3_result", rs, 6);
    check("n3_busy", bc, 6);
    @(negedge CLK);

    // Asynchronous reset in the middle of an N=6 multiply phase
    @(negedge CLK);
    N  = 32'd6;
    GO = 1'b1;
    @(posedge CLK);
    #1 GO = 1'b0;
    for (int i = 0; i < 10 && !CNT_EN; i++) @(negedge CLK);
    check("n6_in_mul", int'(CNT_EN), 1);
    #2 RST_N = 1'b0;
    #1 check("async_reset_outs", int'(outs), 0);
    @(posedge CLK);
    #1 check("reset_held_outs", int'(outs), 0);
    @(negedge CLK) RST_N = 1'b1;
    run(32'd4, 1'b0, dc, ec, bc, en, ml, rs);
    check("n4_done_cyc", dc, 9);
    check("n4_result", rs, 24);
    @(negedge CLK);

    // Unused state encoding recovers to IDLE even with a valid GO pending
    @(negedge CLK);
    N  = 32'd3;
    GO = 1'b1;
    force dut.state = state_t'(3'd6);
    #1 release dut.state;
    #1 check("illegal_outs", int'(outs), 0);
    @(posedge CLK);
    #1 check("illegal_to_idle", int'(dut.state), int'(S_IDLE));
    @(posedge CLK);
    #1 check("illegal_then_load", int'(outs), 7'b1001001);
    GO = 1'b0;
    for (int i = 0; i < 20 && !DONE; i++) @(negedge CLK);
    check("illegal_run_result", int'(dout), 6);

    repeat (2) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
